// File: rtl/spi_flash_ctrl_if.sv
// Bus request/response bundle between the core's bus decoder and the flash read controller.
// The requester holds sel/address until ready; ready is a one-cycle completion pulse.
interface spi_flash_ctrl_if;
  logic        sel;
  logic        read_en;
  logic [3:0]  write_mask;
  logic [23:0] address;
  logic [31:0] read_value;
  logic        ready;

  modport master (output sel, read_en, write_mask, address, input read_value, ready);
  modport slave  (input sel, read_en, write_mask, address, output read_value, ready);
endinterface

// File: rtl/spi_flash_ctrl.sv
// Turns each bus read into one SPI mode-0 READ (cmd, 24-bit addr, 32 data bits); ready 1+128*CLK_DIV cycles after accept.
// Writes are acknowledged the next cycle with zero data; no new request is taken until the current one completes.
module spi_flash_ctrl #(
  parameter int unsigned CLK_DIV  = 1,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic             clk,
  input  logic             reset,
  spi_flash_ctrl_if.slave  bus,
  output logic             flash_clk,
  output logic             flash_csn,
  output logic             flash_io0_en,
  output logic             flash_io0_out,
  input  logic             flash_io0_in,
  output logic             flash_io1_en,
  output logic             flash_io1_out,
  input  logic             flash_io1_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_OUT, SHIFT_IN, DONE, GAP, WACK} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      shreg;
  logic             phase_end;
  logic             unused_ok;

  assign phase_end     = (div_cnt == DIV_LAST);
  assign flash_io1_en  = 1'b0;
  assign flash_io1_out = 1'b0;
  assign unused_ok     = &{1'b0, flash_io0_in, bus.address[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      flash_clk      <= 1'b0;
      flash_csn      <= 1'b1;
      flash_io0_en   <= 1'b0;
      flash_io0_out  <= 1'b0;
      bus.ready      <= 1'b0;
      bus.read_value <= '0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (bus.sel && bus.write_mask != 4'h0) begin
            state          <= WACK;
            bus.ready      <= 1'b1;
            bus.read_value <= '0;
          end else if (bus.sel && bus.read_en) begin
            state         <= SHIFT_OUT;
            shreg         <= {CMD_READ, bus.address[23:2], 2'b00};
            flash_csn     <= 1'b0;
            flash_io0_en  <= 1'b1;
            flash_io0_out <= CMD_READ[7];
          end
        end

        SHIFT_OUT, SHIFT_IN: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_clk) begin
              // Rising edge: the flash has had a full low phase to drive MISO.
              flash_clk <= 1'b1;
              if (state == SHIFT_IN)
                shreg <= {shreg[30:0], flash_io1_in};
            end else begin
              flash_clk <= 1'b0;
              if (bit_cnt != 6'd63)
                bit_cnt <= bit_cnt + 1'b1;
              if (state == SHIFT_OUT) begin
                shreg <= {shreg[30:0], 1'b0};
                if (bit_cnt == 6'd31) begin
                  state         <= SHIFT_IN;
                  flash_io0_en  <= 1'b0;
                  flash_io0_out <= 1'b0;
                end else begin
                  flash_io0_out <= shreg[30];
                end
              end else if (bit_cnt == 6'd63) begin
                // Flash streams the word little-endian, each byte MSB first.
                state          <= DONE;
                flash_csn      <= 1'b1;
                bus.ready      <= 1'b1;
                bus.read_value <= {shreg[7:0], shreg[15:8], shreg[23:16], shreg[31:24]};
              end
            end
          end
        end

        DONE:    state <= GAP;
        GAP:     state <= IDLE;
        WACK:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Scoreboard bench: two controllers (CLK_DIV=1 and 2) with a behavioural mode-0 flash model per instance.
module tb_spi_flash_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_ctrl_if bus0 ();
  spi_flash_ctrl_if bus1 ();

  logic [1:0]        fclk, csn, io0en, io0out, io1en, io1out, miso, rdy;
  logic [1:0][31:0]  rv;
  logic [1:0]        sel_d, rden_d;
  logic [1:0][3:0]   wm_d;
  logic [1:0][23:0]  addr_d;
  logic [1:0][31:0]  flash_word;

  assign bus0.sel = sel_d[0];   assign bus0.read_en = rden_d[0];
  assign bus0.write_mask = wm_d[0]; assign bus0.address = addr_d[0];
  assign bus1.sel = sel_d[1];   assign bus1.read_en = rden_d[1];
  assign bus1.write_mask = wm_d[1]; assign bus1.address = addr_d[1];
  assign rdy[0] = bus0.ready;   assign rv[0] = bus0.read_value;
  assign rdy[1] = bus1.ready;   assign rv[1] = bus1.read_value;

  spi_flash_ctrl #(.CLK_DIV(1), .CMD_READ(8'h03)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .flash_clk(fclk[0]), .flash_csn(csn[0]),
    .flash_io0_en(io0en[0]), .flash_io0_out(io0out[0]), .flash_io0_in(1'b0),
    .flash_io1_en(io1en[0]), .flash_io1_out(io1out[0]), .flash_io1_in(miso[0])
  );

  spi_flash_ctrl #(.CLK_DIV(2), .CMD_READ(8'h03)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .flash_clk(fclk[1]), .flash_csn(csn[1]),
    .flash_io0_en(io0en[1]), .flash_io0_out(io0out[1]), .flash_io0_in(1'b0),
    .flash_io1_en(io1en[1]), .flash_io1_out(io1out[1]), .flash_io1_in(miso[1])
  );

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] val;
    logic [31:0] mosi;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  int               acc[2];
  int               rise_cnt[2];
  int               lo_cnt[2];
  int               hi_run[2];
  logic [1:0][31:0] mosi_cap;
  logic [1:0]       prev_fclk, prev_csn, prev_mosi, bad;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push(int d, bit wr, logic [31:0] val, logic [31:0] mosi, int lat);
    exp_t e;
    e.d = d; e.wr = wr; e.val = val; e.mosi = mosi; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  // Flash model plus monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prev_csn[d] && !csn[d]) begin
        acc[d] = cyc - 1;
        check($sformatf("csn_gap%0d", d), 64'(hi_run[d] >= 2), 64'd1);
        rise_cnt[d] = 0; lo_cnt[d] = 0; bad[d] = 1'b0; mosi_cap[d] = '0;
      end
      if (csn[d]) hi_run[d]++;
      else begin hi_run[d] = 0; lo_cnt[d]++; end

      if (fclk[d] && io0out[d] !== prev_mosi[d]) bad[d] = 1'b1;
      if (!prev_fclk[d] && fclk[d]) begin
        if (rise_cnt[d] < 32) begin
          if (io0en[d] !== 1'b1) bad[d] = 1'b1;
          mosi_cap[d] = {mosi_cap[d][30:0], io0out[d]};
        end else if (io0en[d] !== 1'b0 || io0out[d] !== 1'b0) begin
          bad[d] = 1'b1;
        end
        rise_cnt[d]++;
      end
      if (prev_fclk[d] && !fclk[d] && rise_cnt[d] >= 32 && rise_cnt[d] < 64)
        miso[d] = flash_word[d][63 - rise_cnt[d]];

      if (rdy[d]) begin
        if (exp_q.size() == 0 || exp_q[0].d != d) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ready dut%0d: got ready with value 0x%0h, expected no ready", d, rv[d]);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("read_value%0d", d), rv[d], mon_e.val);
          check($sformatf("latency%0d", d), 64'(cyc - acc[d]), 64'(mon_e.lat));
          if (mon_e.wr) begin
            check($sformatf("write_pins%0d", d), {csn[d], fclk[d], 1'(hi_run[d] >= 2)}, 3'b101);
          end else begin
            check($sformatf("mosi%0d", d), mosi_cap[d], mon_e.mosi);
            check($sformatf("csn_low_cycles%0d", d), 64'(lo_cnt[d]), 64'(128 * (d + 1)));
            check($sformatf("bit_timing%0d", d), bad[d], 1'b0);
          end
        end
      end
      prev_fclk[d] = fclk[d];
      prev_csn[d]  = csn[d];
      prev_mosi[d] = io0out[d];
    end
  end

  task automatic issue(int d, bit wr, logic [23:0] a);
    @(negedge clk);
    addr_d[d] = a;
    sel_d[d]  = 1'b1;
    rden_d[d] = !wr;
    wm_d[d]   = wr ? 4'hF : 4'h0;
    if (wr) acc[d] = cyc;
  endtask

  task automatic wait_ready(int d, int budget, bit release_sel);
    int k = 0;
    while (!rdy[d] && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!rdy[d]) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout dut%0d: no ready within %0d cycles", d, budget);
    end
    if (release_sel) begin
      sel_d[d] = 1'b0; rden_d[d] = 1'b0; wm_d[d] = 4'h0;
    end
  endtask

  initial begin
    sel_d = '0; rden_d = '0; wm_d = '0; addr_d = '0; miso = '0;
    flash_word = '0; mosi_cap = '0;
    prev_fclk = '0; prev_csn = 2'b11; prev_mosi = '0; bad = '0;
    acc = '{0, 0}; rise_cnt = '{0, 0}; lo_cnt = '{0, 0}; hi_run = '{0, 0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("reset_state%0d", d),
            {rdy[d], csn[d], fclk[d], io0en[d], io0out[d], io1en[d], io1out[d], rv[d]},
            {7'b0100000, 32'h0});
    reset = 1'b0;

    // Basic read, CLK_DIV=1
    flash_word[0] = 32'hEFBEADDE;
    push(0, 0, 32'hDEADBEEF, 32'h03000104, 129);
    issue(0, 0, 24'h000104);
    wait_ready(0, 400, 1'b1);

    // Same read, CLK_DIV=2
    flash_word[1] = 32'hEFBEADDE;
    push(1, 0, 32'hDEADBEEF, 32'h03000104, 257);
    issue(1, 0, 24'h000104);
    wait_ready(1, 700, 1'b1);

    // Low address bits dropped; mid-transaction address change ignored
    push(0, 0, 32'hDEADBEEF, 32'h03000104, 129);
    issue(0, 0, 24'h000107);
    repeat (10) @(negedge clk);
    addr_d[0] = 24'hFFFFFF;
    wait_ready(0, 400, 1'b1);

    // Write acknowledged next cycle, flash untouched
    repeat (4) @(negedge clk);
    push(0, 1, 32'h0, 32'h0, 1);
    issue(0, 1, 24'h000200);
    wait_ready(0, 10, 1'b1);
    @(negedge clk);
    check("write_after_pins", {csn[0], fclk[0]}, 2'b10);

    // Reset at cycle 20 of a read aborts it silently
    repeat (3) @(negedge clk);
    issue(0, 0, 24'h000104);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pins", {csn[0], fclk[0], io0en[0], rdy[0]}, 4'b1000);
    reset = 1'b0; sel_d[0] = 1'b0; rden_d[0] = 1'b0;
    repeat (3) @(negedge clk);
    flash_word[0] = 32'h12345678;
    push(0, 0, 32'h78563412, 32'h03000000, 129);
    issue(0, 0, 24'h000000);
    wait_ready(0, 400, 1'b1);

    // Back-to-back reads with sel held high
    repeat (3) @(negedge clk);
    flash_word[0] = 32'h0123ABCD;
    push(0, 0, 32'hCDAB2301, 32'h03000010, 129);
    issue(0, 0, 24'h000010);
    wait_ready(0, 400, 1'b0);
    flash_word[0] = 32'hA5C30F96;
    addr_d[0] = 24'h000020;
    push(0, 0, 32'h960FC3A5, 32'h03000020, 129);
    @(negedge clk);
    wait_ready(0, 400, 1'b1);

    repeat (5) @(negedge clk);
    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
